// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
//   Shared types for the DDS phase-config arbiter:
//     dds_cfg_t    one config word as sent to the DDS, {poff, pinc}
//     cfg_src_e    requester identity (sweep controller / host registers)
//     arb_state_e  arbiter FSM states
//   Optional feature macro used by the files importing this package:
//     DDS_CFG_STATS_EN  adds per-source overwrite counters.
// ---------------------------------------------------------------------------
package dds_pkg;

  typedef struct packed {
    logic [15:0] poff;
    logic [15:0] pinc;
  } dds_cfg_t;

  typedef enum logic {
    SRC_SWEEP = 1'b0,
    SRC_HOST  = 1'b1
  } cfg_src_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

endpackage : dds_pkg

// File: rtl/dds_cfg_slot.sv
// ---------------------------------------------------------------------------
// dds_cfg_slot
//   One latest-wins mailbox for a config requester. A strobe stores the word
//   and raises the pending flag; the arbiter's clear drops the flag once the
//   word has been copied out. A strobe on the same edge as a clear wins, so a
//   word arriving at its own grant edge stays pending for a later round.
//   Optional (DDS_CFG_STATS_EN): saturating count of strobes that land while
//   the slot is already pending, i.e. of words superseded or re-queued.
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   strobe   in   1-clk load request
//   word     in   config word to store
//   clear    in   arbiter has taken the stored word
//   pending  out  slot holds an unserved word
//   data     out  stored word
//   ovr_cnt  out  overwrite counter (DDS_CFG_STATS_EN only)
// ---------------------------------------------------------------------------
module dds_cfg_slot
  import dds_pkg::*;
`ifdef DDS_CFG_STATS_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe,
  input  dds_cfg_t         word,
  input  logic             clear,
`ifdef DDS_CFG_STATS_EN
  output logic [CNT_W-1:0] ovr_cnt,
`endif
  output logic             pending,
  output dds_cfg_t         data
);

  logic     pending_reg;
  dds_cfg_t data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
      data_reg    <= '0;
    end else if (strobe) begin
      pending_reg <= 1'b1;
      data_reg    <= word;
    end else if (clear) begin
      pending_reg <= 1'b0;
    end
  end

`ifdef DDS_CFG_STATS_EN
  logic [CNT_W-1:0] ovr_cnt_reg;

  // Uses the pre-edge pending flag, so a strobe at the grant edge counts too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt_reg <= '0;
    end else if (strobe && pending_reg && (ovr_cnt_reg != {CNT_W{1'b1}})) begin
      ovr_cnt_reg <= ovr_cnt_reg + 1'b1;
    end
  end

  assign ovr_cnt = ovr_cnt_reg;
`endif

  assign pending = pending_reg;
  assign data    = data_reg;

endmodule : dds_cfg_slot

// File: rtl/dds_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// dds_cfg_arbiter
//   Shares the DDS phase-config AXI-Stream channel between the sweep
//   controller and the host register path. Each source has a latest-wins
//   slot; ties are broken round-robin (host wins the first tie after reset).
//   After every accepted word the block waits HOLDOFF_CYCLES clocks so the
//   DDS can settle before the next update.
//   Optional feature macro: DDS_CFG_STATS_EN adds o_sweep_ovr_cnt and
//   o_host_ovr_cnt (CNT_W bits, saturating overwrite counters).
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_sweep_valid/pinc/poff    sweep config strobe and word
//   i_host_valid/pinc/poff     host config strobe and word
//   m_axis_cfg_tvalid/tready   config stream handshake to the DDS
//   m_axis_cfg_tdata           {poff, pinc}
//   o_busy                     FSM not idle
//   o_applied_pinc             pinc of the last accepted word
//   o_cfg_done                 1-clk pulse after each accepted word
//   o_grant_src                source of the last accepted word (1 = host)
// ---------------------------------------------------------------------------
module dds_cfg_arbiter
  import dds_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 4
`ifdef DDS_CFG_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sweep_valid,
  input  logic [15:0]      i_sweep_pinc,
  input  logic [15:0]      i_sweep_poff,
  input  logic             i_host_valid,
  input  logic [15:0]      i_host_pinc,
  input  logic [15:0]      i_host_poff,
  output logic             m_axis_cfg_tvalid,
  input  logic             m_axis_cfg_tready,
  output logic [31:0]      m_axis_cfg_tdata,
`ifdef DDS_CFG_STATS_EN
  output logic [CNT_W-1:0] o_sweep_ovr_cnt,
  output logic [CNT_W-1:0] o_host_ovr_cnt,
`endif
  output logic             o_busy,
  output logic [15:0]      o_applied_pinc,
  output logic             o_cfg_done,
  output logic             o_grant_src
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SEND = SEND;
  localparam logic [1:0] ST_HOLD = HOLD;

  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  // Slot index 0 = sweep, 1 = host, matching cfg_src_e.
  logic     slot_strobe  [2];
  dds_cfg_t slot_word    [2];
  logic     slot_clear   [2];
  logic     slot_pending [2];
  dds_cfg_t slot_data    [2];
`ifdef DDS_CFG_STATS_EN
  logic [CNT_W-1:0] slot_ovr_cnt [2];
`endif

  assign slot_strobe[0] = i_sweep_valid;
  assign slot_word[0]   = '{poff: i_sweep_poff, pinc: i_sweep_pinc};
  assign slot_strobe[1] = i_host_valid;
  assign slot_word[1]   = '{poff: i_host_poff, pinc: i_host_pinc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    dds_cfg_slot
`ifdef DDS_CFG_STATS_EN
    #(.CNT_W(CNT_W))
`endif
    u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .strobe  (slot_strobe[gi]),
      .word    (slot_word[gi]),
      .clear   (slot_clear[gi]),
`ifdef DDS_CFG_STATS_EN
      .ovr_cnt (slot_ovr_cnt[gi]),
`endif
      .pending (slot_pending[gi]),
      .data    (slot_data[gi])
    );
  end

  logic [1:0]        state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  cfg_src_e          last_grant_reg, last_grant_next;
  cfg_src_e          cur_src_reg, cur_src_next;
  cfg_src_e          grant_src_reg, grant_src_next;
  logic              tvalid_reg, tvalid_next;
  dds_cfg_t          tdata_reg, tdata_next;
  logic [15:0]       applied_pinc_reg, applied_pinc_next;
  logic              cfg_done_reg, cfg_done_next;

  logic grant_fire;
  logic grant_host;

  // Host gets the grant when it is the only one waiting, or on a tie when
  // the sweep side won the previous round.
  assign grant_fire = (state_reg == ST_IDLE) && (slot_pending[0] || slot_pending[1]);
  assign grant_host = slot_pending[1] &&
                      (!slot_pending[0] || (last_grant_reg == SRC_SWEEP));

  assign slot_clear[0] = grant_fire && !grant_host;
  assign slot_clear[1] = grant_fire && grant_host;

  always_comb begin
    state_next        = state_reg;
    hold_cnt_next     = hold_cnt_reg;
    last_grant_next   = last_grant_reg;
    cur_src_next      = cur_src_reg;
    grant_src_next    = grant_src_reg;
    tvalid_next       = tvalid_reg;
    tdata_next        = tdata_reg;
    applied_pinc_next = applied_pinc_reg;
    cfg_done_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (grant_fire) begin
          cur_src_next    = grant_host ? SRC_HOST : SRC_SWEEP;
          last_grant_next = grant_host ? SRC_HOST : SRC_SWEEP;
          tdata_next      = grant_host ? slot_data[1] : slot_data[0];
          tvalid_next     = 1'b1;
          state_next      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_axis_cfg_tready) begin
          tvalid_next       = 1'b0;
          applied_pinc_next = tdata_reg.pinc;
          grant_src_next    = cur_src_reg;
          cfg_done_next     = 1'b1;
          hold_cnt_next     = '0;
          state_next        = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          state_next = ST_IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        tvalid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      hold_cnt_reg     <= '0;
      last_grant_reg   <= SRC_SWEEP;
      cur_src_reg      <= SRC_SWEEP;
      grant_src_reg    <= SRC_SWEEP;
      tvalid_reg       <= 1'b0;
      tdata_reg        <= '0;
      applied_pinc_reg <= '0;
      cfg_done_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      hold_cnt_reg     <= hold_cnt_next;
      last_grant_reg   <= last_grant_next;
      cur_src_reg      <= cur_src_next;
      grant_src_reg    <= grant_src_next;
      tvalid_reg       <= tvalid_next;
      tdata_reg        <= tdata_next;
      applied_pinc_reg <= applied_pinc_next;
      cfg_done_reg     <= cfg_done_next;
    end
  end

  assign m_axis_cfg_tvalid = tvalid_reg;
  assign m_axis_cfg_tdata  = tdata_reg;
  assign o_busy            = (state_reg != ST_IDLE);
  assign o_applied_pinc    = applied_pinc_reg;
  assign o_cfg_done        = cfg_done_reg;
  assign o_grant_src       = grant_src_reg;

`ifdef DDS_CFG_STATS_EN
  assign o_sweep_ovr_cnt = slot_ovr_cnt[0];
  assign o_host_ovr_cnt  = slot_ovr_cnt[1];
`endif

endmodule : dds_cfg_arbiter
